// File: rtl/ysyx_23060208_rd_arbiter.sv
// Two-master read arbiter for the shared SRAM read port.
// The IFU (M0) and the LSU (M1) compete for one AXI-lite AR/R slave.
// Only one transaction is in flight at a time. Ties go round-robin.
// The grant is held from the AR accept until the R handshake.
module ysyx_23060208_rd_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  // M0: instruction fetch
  input  logic [DATA_WIDTH-1:0] ifu_araddr,
  input  logic                  ifu_arvalid,
  output logic                  ifu_arready,
  output logic [DATA_WIDTH-1:0] ifu_rdata,
  output logic [1:0]            ifu_rresp,
  output logic                  ifu_rvalid,
  input  logic                  ifu_rready,
  // M1: load/store unit
  input  logic [DATA_WIDTH-1:0] lsu_araddr,
  input  logic                  lsu_arvalid,
  output logic                  lsu_arready,
  output logic [DATA_WIDTH-1:0] lsu_rdata,
  output logic [1:0]            lsu_rresp,
  output logic                  lsu_rvalid,
  input  logic                  lsu_rready,
  // Shared SRAM read port
  output logic [DATA_WIDTH-1:0] mem_araddr,
  output logic                  mem_arvalid,
  input  logic                  mem_arready,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic [1:0]            mem_rresp,
  input  logic                  mem_rvalid,
  output logic                  mem_rready,
  // One-hot current owner {M1,M0}. Reads 00 while idle.
  output logic [1:0]            arb_grant
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    RESP
  } state_t;

  state_t     state;
  logic [1:0] owner;
  // last_grant is 1 when M1 won the previous transaction and 0 when M0 did.
  logic       last_grant;
  logic       pick_ifu;
  logic       pick_lsu;
  logic       in_idle;
  logic       in_resp;

  assign in_idle = (state == IDLE);
  assign in_resp = (state == RESP);

  // A lone requester wins outright; on a tie the master that did not win last time wins
  always_comb begin
    pick_ifu = ifu_arvalid & (~lsu_arvalid | last_grant);
    pick_lsu = lsu_arvalid & (~ifu_arvalid | ~last_grant);
  end

  // arready is gated by rst so that no handshake can be offered while reset is held
  assign ifu_arready = rst & in_idle & pick_ifu;
  assign lsu_arready = rst & in_idle & pick_lsu;

  assign ifu_rdata   = mem_rdata;
  assign lsu_rdata   = mem_rdata;
  assign ifu_rvalid  = in_resp & owner[0] & mem_rvalid;
  assign lsu_rvalid  = in_resp & owner[1] & mem_rvalid;
  assign ifu_rresp   = (in_resp & owner[0]) ? mem_rresp : 2'b00;
  assign lsu_rresp   = (in_resp & owner[1]) ? mem_rresp : 2'b00;
  assign mem_rready  = in_resp & ((owner[0] & ifu_rready) | (owner[1] & lsu_rready));
  assign arb_grant   = owner;

  // Arbitration FSM: accept a master in IDLE, present its address in ADDR, return data in RESP
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      mem_arvalid <= 1'b0;
      mem_araddr  <= '0;
      owner       <= 2'b00;
      last_grant  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (pick_ifu) begin
            mem_araddr  <= ifu_araddr;
            mem_arvalid <= 1'b1;
            owner       <= 2'b01;
            state       <= ADDR;
          end else if (pick_lsu) begin
            mem_araddr  <= lsu_araddr;
            mem_arvalid <= 1'b1;
            owner       <= 2'b10;
            state       <= ADDR;
          end
        end
        ADDR: begin
          if (mem_arready) begin
            mem_arvalid <= 1'b0;
            state       <= RESP;
          end
        end
        RESP: begin
          if (mem_rvalid && mem_rready) begin
            last_grant <= owner[1];
            owner      <= 2'b00;
            state      <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          mem_arvalid <= 1'b0;
          owner       <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060208_rd_arbiter.sv
// Testbench for ysyx_23060208_rd_arbiter.
// It runs directed scenarios and then random traffic.
// Every output is compared against a transaction-level model of the arbiter.
module tb_ysyx_23060208_rd_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] ifu_araddr;
  logic        ifu_arvalid;
  logic        ifu_arready;
  logic [31:0] ifu_rdata;
  logic [1:0]  ifu_rresp;
  logic        ifu_rvalid;
  logic        ifu_rready;
  logic [31:0] lsu_araddr;
  logic        lsu_arvalid;
  logic        lsu_arready;
  logic [31:0] lsu_rdata;
  logic [1:0]  lsu_rresp;
  logic        lsu_rvalid;
  logic        lsu_rready;
  logic [31:0] mem_araddr;
  logic        mem_arvalid;
  logic        mem_arready;
  logic [31:0] mem_rdata;
  logic [1:0]  mem_rresp;
  logic        mem_rvalid;
  logic        mem_rready;
  logic [1:0]  arb_grant;

  int n_checks = 0;
  int n_errors = 0;

  // Transaction-level model.
  // m_owner is -1 when no transaction is in flight, and 0 or 1 for the master that owns it.
  // m_ar_pending stays set until the SRAM accepts the address.
  int          m_owner;
  bit          m_ar_pending;
  logic [31:0] m_addr;
  int          m_last;

  logic [31:0] addr_seen[$];

  ysyx_23060208_rd_arbiter #(.DATA_WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .ifu_araddr  (ifu_araddr),
    .ifu_arvalid (ifu_arvalid),
    .ifu_arready (ifu_arready),
    .ifu_rdata   (ifu_rdata),
    .ifu_rresp   (ifu_rresp),
    .ifu_rvalid  (ifu_rvalid),
    .ifu_rready  (ifu_rready),
    .lsu_araddr  (lsu_araddr),
    .lsu_arvalid (lsu_arvalid),
    .lsu_arready (lsu_arready),
    .lsu_rdata   (lsu_rdata),
    .lsu_rresp   (lsu_rresp),
    .lsu_rvalid  (lsu_rvalid),
    .lsu_rready  (lsu_rready),
    .mem_araddr  (mem_araddr),
    .mem_arvalid (mem_arvalid),
    .mem_arready (mem_arready),
    .mem_rdata   (mem_rdata),
    .mem_rresp   (mem_rresp),
    .mem_rvalid  (mem_rvalid),
    .mem_rready  (mem_rready),
    .arb_grant   (arb_grant)
  );

  // 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the sequence ever stalls
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner      = -1;
    m_ar_pending = 1'b0;
    m_addr       = 32'h0;
    m_last       = 1;
  endtask

  // Round-robin pick among the masters requesting right now; -1 if none
  function automatic int model_winner();
    if (ifu_arvalid && lsu_arvalid) return (m_last + 1) % 2;
    if (ifu_arvalid) return 0;
    if (lsu_arvalid) return 1;
    return -1;
  endfunction

  task automatic verify_model();
    int   w;
    bit   responding;
    logic owner_rready;
    w = (m_owner < 0) ? model_winner() : -1;
    responding = (m_owner >= 0) && !m_ar_pending;
    owner_rready = (m_owner == 1) ? lsu_rready : ifu_rready;
    check_output("ifu_arready", {31'b0, ifu_arready}, {31'b0, w == 0});
    check_output("lsu_arready", {31'b0, lsu_arready}, {31'b0, w == 1});
    check_output("mem_arvalid", {31'b0, mem_arvalid}, {31'b0, (m_owner >= 0) && m_ar_pending});
    check_output("mem_araddr", mem_araddr, m_addr);
    check_output("arb_grant", {30'b0, arb_grant}, (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
    check_output("ifu_rvalid", {31'b0, ifu_rvalid}, {31'b0, responding && m_owner == 0 && mem_rvalid});
    check_output("lsu_rvalid", {31'b0, lsu_rvalid}, {31'b0, responding && m_owner == 1 && mem_rvalid});
    check_output("mem_rready", {31'b0, mem_rready}, {31'b0, responding && owner_rready});
    check_output("ifu_rdata", ifu_rdata, mem_rdata);
    check_output("lsu_rdata", lsu_rdata, mem_rdata);
    if (responding && m_owner == 0) check_output("ifu_rresp", {30'b0, ifu_rresp}, {30'b0, mem_rresp});
    if (responding && m_owner == 1) check_output("lsu_rresp", {30'b0, lsu_rresp}, {30'b0, mem_rresp});
  endtask

  // Drive one cycle of inputs after the falling edge, then compare the settled outputs with the model
  task automatic apply_stimulus(input logic iv, input logic [31:0] ia, input logic lv,
                                input logic [31:0] la, input logic irr, input logic lrr,
                                input logic marr, input logic mrv, input logic [31:0] mrd,
                                input logic [1:0] mrsp);
    @(negedge clk);
    ifu_arvalid = iv;
    ifu_araddr  = ia;
    lsu_arvalid = lv;
    lsu_araddr  = la;
    ifu_rready  = irr;
    lsu_rready  = lrr;
    mem_arready = marr;
    mem_rvalid  = mrv;
    mem_rdata   = mrd;
    mem_rresp   = mrsp;
    #1;
    verify_model();
  endtask

  // Advance the model across the rising edge using the inputs that were held for the cycle
  task automatic clock_edge();
    int   w;
    logic owner_rready;
    @(posedge clk);
    if (m_owner < 0) begin
      w = model_winner();
      if (w >= 0) begin
        m_owner      = w;
        m_addr       = (w == 1) ? lsu_araddr : ifu_araddr;
        m_ar_pending = 1'b1;
      end
    end else if (m_ar_pending) begin
      if (mem_arready) m_ar_pending = 1'b0;
    end else begin
      owner_rready = (m_owner == 1) ? lsu_rready : ifu_rready;
      if (mem_rvalid && owner_rready) begin
        m_last  = m_owner;
        m_owner = -1;
      end
    end
  endtask

  initial begin
    rst         = 1'b0;
    ifu_arvalid = 1'b1;
    ifu_araddr  = 32'h80000000;
    lsu_arvalid = 1'b0;
    lsu_araddr  = 32'h0;
    ifu_rready  = 1'b1;
    lsu_rready  = 1'b1;
    mem_arready = 1'b0;
    mem_rvalid  = 1'b1;
    mem_rdata   = 32'h0;
    mem_rresp   = 2'b00;
    model_reset();

    // Nothing may be offered while reset is held, even with a request pending
    @(negedge clk);
    #1;
    check_output("reset_ifu_arready", {31'b0, ifu_arready}, 32'd0);
    check_output("reset_mem_arvalid", {31'b0, mem_arvalid}, 32'd0);
    check_output("reset_mem_araddr", mem_araddr, 32'd0);
    check_output("reset_mem_rready", {31'b0, mem_rready}, 32'd0);
    check_output("reset_arb_grant", {30'b0, arb_grant}, 32'd0);
    ifu_arvalid = 1'b0;
    mem_rvalid  = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    $display("[TB] single IFU fetch");
    apply_stimulus(1, 32'h80000000, 0, 32'h0, 1, 1, 1, 0, 32'h0, 2'b00);
    check_output("t1_c0_ifu_arready", {31'b0, ifu_arready}, 32'd1);
    clock_edge();
    apply_stimulus(0, 32'h0, 0, 32'h0, 1, 1, 1, 0, 32'h0, 2'b00);
    check_output("t1_c1_mem_arvalid", {31'b0, mem_arvalid}, 32'd1);
    check_output("t1_c1_mem_araddr", mem_araddr, 32'h80000000);
    check_output("t1_c1_grant", {30'b0, arb_grant}, 32'd1);
    clock_edge();
    apply_stimulus(0, 32'h0, 0, 32'h0, 1, 1, 1, 1, 32'h00000413, 2'b00);
    check_output("t1_c2_ifu_rvalid", {31'b0, ifu_rvalid}, 32'd1);
    check_output("t1_c2_ifu_rdata", ifu_rdata, 32'h00000413);
    check_output("t1_c2_lsu_rvalid", {31'b0, lsu_rvalid}, 32'd0);
    check_output("t1_c2_grant", {30'b0, arb_grant}, 32'd1);
    clock_edge();

    $display("[TB] continuous tie from reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 9; i++) begin
      apply_stimulus(1, 32'h80000004, 1, 32'h80001000, 1, 1, 1, 1, 32'h1000 + i, 2'b00);
      if (mem_arvalid) addr_seen.push_back(mem_araddr);
      clock_edge();
    end
    check_output("t2_count", addr_seen.size(), 32'd3);
    if (addr_seen.size() == 3) begin
      check_output("t2_addr0", addr_seen[0], 32'h80000004);
      check_output("t2_addr1", addr_seen[1], 32'h80001000);
      check_output("t2_addr2", addr_seen[2], 32'h80000004);
    end
    apply_stimulus(0, 32'h0, 0, 32'h0, 1, 1, 0, 0, 32'h0, 2'b00);
    clock_edge();

    $display("[TB] slave stall, owner backpressure, error response");
    apply_stimulus(0, 32'h0, 1, 32'h80002000, 1, 0, 0, 0, 32'h0, 2'b00);
    check_output("t3_lsu_arready", {31'b0, lsu_arready}, 32'd1);
    clock_edge();
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(0, 32'h0, 0, 32'h0, 1, 0, 0, 0, 32'h0, 2'b00);
      check_output("t3_stall_arvalid", {31'b0, mem_arvalid}, 32'd1);
      check_output("t3_stall_araddr", mem_araddr, 32'h80002000);
      clock_edge();
    end
    apply_stimulus(0, 32'h0, 0, 32'h0, 1, 0, 1, 0, 32'h0, 2'b00);
    clock_edge();
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1, 32'h80000020, 0, 32'h0, 1, 0, 0, 1, 32'h55aa55aa, 2'b00);
      check_output("t4_mem_rready", {31'b0, mem_rready}, 32'd0);
      check_output("t4_grant", {30'b0, arb_grant}, 32'd2);
      clock_edge();
    end
    apply_stimulus(1, 32'h80000020, 0, 32'h0, 1, 1, 0, 1, 32'hdeadbeef, 2'b10);
    check_output("t5_lsu_rresp", {30'b0, lsu_rresp}, 32'd2);
    check_output("t5_lsu_rvalid", {31'b0, lsu_rvalid}, 32'd1);
    check_output("t5_ifu_rvalid", {31'b0, ifu_rvalid}, 32'd0);
    check_output("t5_ifu_arready", {31'b0, ifu_arready}, 32'd0);
    clock_edge();
    apply_stimulus(0, 32'h0, 0, 32'h0, 1, 1, 0, 0, 32'h0, 2'b00);
    clock_edge();

    $display("[TB] asynchronous reset during address phase");
    apply_stimulus(1, 32'h80000010, 0, 32'h0, 1, 1, 0, 0, 32'h0, 2'b00);
    clock_edge();
    apply_stimulus(1, 32'h80000010, 1, 32'h80003000, 1, 1, 0, 0, 32'h0, 2'b00);
    clock_edge();
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_output("t6_mem_arvalid", {31'b0, mem_arvalid}, 32'd0);
    check_output("t6_grant", {30'b0, arb_grant}, 32'd0);
    check_output("t6_ifu_arready", {31'b0, ifu_arready}, 32'd0);
    check_output("t6_lsu_arready", {31'b0, lsu_arready}, 32'd0);
    check_output("t6_mem_rready", {31'b0, mem_rready}, 32'd0);
    model_reset();
    ifu_arvalid = 1'b0;
    lsu_arvalid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    apply_stimulus(1, 32'h80000030, 1, 32'h80004000, 1, 1, 1, 0, 32'h0, 2'b00);
    check_output("t6_tie_ifu", {31'b0, ifu_arready}, 32'd1);
    check_output("t6_tie_lsu", {31'b0, lsu_arready}, 32'd0);
    clock_edge();

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      apply_stimulus(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), $urandom,
                     1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                     2'($urandom_range(0, 3)));
      clock_edge();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
